stopwatch_bcd_chain: RTL and testbench

//  Parametrised BCD stopwatch/timer core; successor of the fixed 4-digit stopwatch.
//  N-digit cascaded BCD counter: per-digit modulus (10 or 6), up or down counting,

---
 rtl/stopwatch_bcd_chain_pkg.sv | 9 +
 rtl/stopwatch_bcd_chain_if.sv | 12 +
 rtl/stopwatch_bcd_chain_digit_cell.sv | 21 ++
 rtl/stopwatch_bcd_chain.sv | 95 +++++++++
 tb/tb_stopwatch_bcd_chain.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_bcd_chain_pkg.sv
// stopwatch_pkg: shared types and helpers for the BCD stopwatch chain
package stopwatch_pkg;
  localparam int MAX_DIGITS = 8;
  typedef logic [3:0] bcd_t;
  typedef enum logic [1:0] {IDLE, RUN, SET} state_t;
  function automatic bcd_t digit_max(input int k, input logic [MAX_DIGITS-1:0] mask);
    return mask[k] ? 4'd5 : 4'd9;
  endfunction
endpackage

// File: rtl/stopwatch_bcd_chain_if.sv
// stopwatch_bcd_chain_if: button pulses, count direction and display/status outputs
//  master: button/board side (drives *_i, reads *_o); slave: stopwatch core
interface stopwatch_bcd_chain_if #(parameter int DIGITS = 4);
  logic start_stop_i, set_i, change_i, down_i, lap_i;
  logic [4*DIGITS-1:0] digits_o, lap_o;
  logic running_o, set_mode_o, wrap_o, done_o;
  logic [2:0] set_digit_o;
  modport master(output start_stop_i, set_i, change_i, down_i, lap_i,
                 input digits_o, lap_o, running_o, set_mode_o, set_digit_o, wrap_o, done_o);
  modport slave(input start_stop_i, set_i, change_i, down_i, lap_i,
                output digits_o, lap_o, running_o, set_mode_o, set_digit_o, wrap_o, done_o);
endinterface

// File: rtl/stopwatch_bcd_chain_digit_cell.sv
// bcd_digit_cell: one BCD digit, steps up/down on step_en, increments on inc_en
//  ports: clk100_i, rst_i (async high), step_en, down, inc_en, max_val -> value, at_max, at_zero
import stopwatch_pkg::*;
module bcd_digit_cell (
  input  logic clk100_i,
  input  logic rst_i,
  input  logic step_en,
  input  logic down,
  input  logic inc_en,
  input  bcd_t max_val,
  output bcd_t value,
  output logic at_max,
  output logic at_zero
);
  assign at_max = value == max_val;
  assign at_zero = value == '0;
  always_ff @(posedge clk100_i or posedge rst_i)
    if (rst_i) value <= '0;
    else if (inc_en || (step_en && !down)) value <= at_max ? '0 : value + 1'b1;
    else if (step_en) value <= at_zero ? max_val : value - 1'b1;
endmodule

// File: rtl/stopwatch_bcd_chain.sv
// stopwatch_bcd_chain: N-digit cascaded BCD stopwatch/timer with set mode
//  ports: clk100_i, rst_i (async high), bus (stopwatch_bcd_chain_if.slave)
//  optional: define LAP_CAPTURE_EN to add the lap capture register
import stopwatch_pkg::*;
module stopwatch_bcd_chain #(
  parameter int DIGITS = 4,
  parameter int TICK_DIV = 1_000_000,
  parameter logic [MAX_DIGITS-1:0] MOD6_MASK = '0
) (
  input logic clk100_i,
  input logic rst_i,
  stopwatch_bcd_chain_if.slave bus
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  state_t state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [PW-1:0] pre_q, pre_d;
  logic tick, zero_all, one_all, wrap_d, done_d, wrap_q, done_q;
  logic [DIGITS:0] carry;
  logic [DIGITS-1:0] at_max, at_zero, inc_en;
  logic [4*DIGITS-1:0] digits;
  assign tick = state_q == RUN && pre_q == PW'(TICK_DIV - 1);
  assign carry[0] = tick;
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    // a digit steps only when every lower digit is about to roll over
    assign carry[k+1] = carry[k] && (bus.down_i ? at_zero[k] : at_max[k]);
    assign inc_en[k] = state_q == SET && bus.change_i && !bus.set_i && sel_q == 3'(k);
    bcd_digit_cell u_cell (
      .clk100_i(clk100_i),
      .rst_i(rst_i),
      .step_en(carry[k]),
      .down(bus.down_i),
      .inc_en(inc_en[k]),
      .max_val(digit_max(k, MOD6_MASK)),
      .value(digits[4*k +: 4]),
      .at_max(at_max[k]),
      .at_zero(at_zero[k])
    );
  end
  assign zero_all = &at_zero;
  // value one: LSD is 1 and every higher digit is zero
  assign one_all = digits[3:0] == 4'd1 && &(at_zero | DIGITS'(1));
  assign wrap_d = tick && !bus.down_i && &at_max;
  assign done_d = tick && bus.down_i && one_all;
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    pre_d = state_q == RUN ? (tick ? '0 : pre_q + 1'b1) : pre_q;
    case (state_q)
      IDLE:
        if (bus.start_stop_i) state_d = bus.down_i && zero_all ? IDLE : RUN;
        else if (bus.set_i) begin
          state_d = SET;
          sel_d = '0;
          pre_d = '0;
        end
      RUN: state_d = bus.start_stop_i || done_d ? IDLE : RUN;
      SET:
        if (bus.set_i) begin
          state_d = sel_q == 3'(DIGITS - 1) ? IDLE : SET;
          sel_d = sel_q == 3'(DIGITS - 1) ? '0 : sel_q + 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk100_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      sel_q <= '0;
      pre_q <= '0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      pre_q <= pre_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
`ifdef LAP_CAPTURE_EN
  logic [4*DIGITS-1:0] lap_q;
  always_ff @(posedge clk100_i or posedge rst_i)
    if (rst_i) lap_q <= '0;
    else if (bus.lap_i && state_q != SET) lap_q <= digits;
  assign bus.lap_o = lap_q;
`else
  assign bus.lap_o = '0;
`endif
  assign bus.digits_o = digits;
  assign bus.running_o = state_q == RUN;
  assign bus.set_mode_o = state_q == SET;
  assign bus.set_digit_o = sel_q;
  assign bus.wrap_o = wrap_q;
  assign bus.done_o = done_q;
endmodule

// File: tb/tb_stopwatch_bcd_chain.sv
// tb_stopwatch_bcd_chain: random + directed check of two stopwatch cores against an integer model
module tb_stopwatch_bcd_chain;
  logic clk = 0, rst = 1;
  logic ss = 0, se = 0, ch = 0, dn = 0, lp = 0;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  stopwatch_bcd_chain_if #(.DIGITS(4)) if0 ();
  stopwatch_bcd_chain_if #(.DIGITS(4)) if6 ();
  assign if0.start_stop_i = ss;
  assign if0.set_i = se;
  assign if0.change_i = ch;
  assign if0.down_i = dn;
  assign if0.lap_i = lp;
  assign if6.start_stop_i = ss;
  assign if6.set_i = se;
  assign if6.change_i = ch;
  assign if6.down_i = dn;
  assign if6.lap_i = lp;
  stopwatch_bcd_chain #(.DIGITS(4), .TICK_DIV(4), .MOD6_MASK(8'b0000_0000)) u_dut0 (
    .clk100_i(clk), .rst_i(rst), .bus(if0));
  stopwatch_bcd_chain #(.DIGITS(4), .TICK_DIV(4), .MOD6_MASK(8'b0000_1000)) u_dut6 (
    .clk100_i(clk), .rst_i(rst), .bus(if6));
  logic [15:0] dig[2], lapo[2];
  logic [2:0] seld[2];
  logic run[2], setm[2], wrp[2], don[2];
  assign dig[0] = if0.digits_o;
  assign dig[1] = if6.digits_o;
  assign lapo[0] = if0.lap_o;
  assign lapo[1] = if6.lap_o;
  assign seld[0] = if0.set_digit_o;
  assign seld[1] = if6.set_digit_o;
  assign run[0] = if0.running_o;
  assign run[1] = if6.running_o;
  assign setm[0] = if0.set_mode_o;
  assign setm[1] = if6.set_mode_o;
  assign wrp[0] = if0.wrap_o;
  assign wrp[1] = if6.wrap_o;
  assign don[0] = if0.done_o;
  assign don[1] = if6.done_o;
  // model: count held as a mixed-radix integer; st 0=idle 1=run 2=set
  int st[2], v[2], sel[2], ph[2], lapv[2];
  bit mw[2], md[2];
  function automatic int rad(int i, int k);
    return (i == 1 && k == 3) ? 6 : 10;
  endfunction
  function automatic int wt(int i, int k);
    int w = 1;
    for (int j = 0; j < k; j++) w *= rad(i, j);
    return w;
  endfunction
  function automatic logic [15:0] bcd(int i, int val);
    logic [15:0] r;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(val % rad(i, k));
      val = val / rad(i, k);
    end
    return r;
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    else n_pass++;
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      st[i] = 0; v[i] = 0; sel[i] = 0; ph[i] = 0; lapv[i] = 0; mw[i] = 0; md[i] = 0;
    end
  endtask
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit tick;
      int d, t;
      tick = st[i] == 1 && ph[i] == 3;
      t = wt(i, 4);
      mw[i] = 0;
      md[i] = 0;
      if (lp && st[i] != 2) lapv[i] = v[i];
      if (st[i] == 1) ph[i] = tick ? 0 : ph[i] + 1;
      if (tick) begin
        if (dn) begin
          v[i] = (v[i] + t - 1) % t;
          md[i] = v[i] == 0;
        end else begin
          v[i] = (v[i] + 1) % t;
          mw[i] = v[i] == 0;
        end
      end
      case (st[i])
        0: if (ss) begin
             if (!(dn && v[i] == 0)) st[i] = 1;
           end else if (se) begin
             st[i] = 2; sel[i] = 0; ph[i] = 0;
           end
        1: if (ss || md[i]) st[i] = 0;
        default:
          if (se) begin
            if (sel[i] == 3) begin st[i] = 0; sel[i] = 0; end
            else sel[i]++;
          end else if (ch) begin
            d = (v[i] / wt(i, sel[i])) % rad(i, sel[i]);
            v[i] += (d == rad(i, sel[i]) - 1) ? -d * wt(i, sel[i]) : wt(i, sel[i]);
          end
      endcase
    end
  endtask
  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("digits%0d", i), 32'(dig[i]), 32'(bcd(i, v[i])));
      check($sformatf("running%0d", i), 32'(run[i]), 32'(st[i] == 1));
      check($sformatf("set_mode%0d", i), 32'(setm[i]), 32'(st[i] == 2));
      check($sformatf("set_digit%0d", i), 32'(seld[i]), 32'(sel[i]));
      check($sformatf("wrap%0d", i), 32'(wrp[i]), 32'(mw[i]));
      check($sformatf("done%0d", i), 32'(don[i]), 32'(md[i]));
`ifdef LAP_CAPTURE_EN
      check($sformatf("lap%0d", i), 32'(lapo[i]), 32'(bcd(i, lapv[i])));
`else
      check($sformatf("lap%0d", i), 32'(lapo[i]), 32'h0);
`endif
    end
  endtask
  task automatic cyc(input logic a, input logic b, input logic c, input logic l);
    ss = a; se = b; ch = c; lp = l;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask
  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(0, 0, 0, 0);
  endtask
  task automatic areset();
    ss = 0; se = 0; ch = 0; lp = 0;
    #2 rst = 1;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    #1 compare_all();
    rst = 0;
  endtask
  task automatic set_digits(input int d0, input int d1, input int d2, input int d3);
    int ds[4];
    ds = '{d0, d1, d2, d3};
    cyc(0, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < ds[k]; j++) cyc(0, 0, 1, 0);
      cyc(0, 1, 0, 0);
    end
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare_all();
    rst = 0;
    cyc(1, 0, 0, 0);
    idle(40);
    check("up40_digits", 32'(dig[0]), 32'h0010);
    check("up40_running", 32'(run[0]), 32'h1);
    areset();
    set_digits(9, 9, 9, 9);
    cyc(1, 0, 0, 0);
    idle(4);
    check("wrap_digits", 32'(dig[0]), 32'h0000);
    check("wrap_pulse", 32'(wrp[0]), 32'h1);
    idle(1);
    check("wrap_one_cycle", 32'(wrp[0]), 32'h0);
    check("wrap_running", 32'(run[0]), 32'h1);
    areset();
    set_digits(2, 0, 0, 0);
    dn = 1;
    cyc(1, 0, 0, 0);
    idle(8);
    check("down_digits", 32'(dig[0]), 32'h0000);
    check("down_done", 32'(don[0]), 32'h1);
    check("down_idle", 32'(run[0]), 32'h0);
    cyc(1, 0, 0, 0);
    check("down_zero_stays", 32'(run[0]), 32'h0);
    dn = 0;
    areset();
    cyc(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0);
    for (int j = 0; j < 6; j++) cyc(0, 0, 1, 0);
    check("mod6_digit3", 32'(dig[1][15:12]), 32'h0);
    check("mod10_digit3", 32'(dig[0][15:12]), 32'h6);
    cyc(0, 1, 0, 0);
    areset();
    set_digits(9, 9, 9, 5);
    cyc(1, 0, 0, 0);
    idle(4);
    check("mod6_wrap_digits", 32'(dig[1]), 32'h0000);
    check("mod6_wrap_pulse", 32'(wrp[1]), 32'h1);
    check("mod10_carry", 32'(dig[0]), 32'h6000);
    areset();
    cyc(1, 1, 0, 0);
    check("prio_run", 32'(run[0]), 32'h1);
    check("prio_not_set", 32'(setm[0]), 32'h0);
    idle(13);
    areset();
    check("reset_digits", 32'(dig[0]), 32'h0);
    check("reset_running", 32'(run[0]), 32'h0);
    cyc(1, 0, 0, 0);
    idle(100);
    check("lap_pre_digits", 32'(dig[0]), 32'h0025);
    cyc(0, 0, 0, 1);
    idle(20);
`ifdef LAP_CAPTURE_EN
    check("lap_value", 32'(lapo[0]), 32'h0025);
`else
    check("lap_tied", 32'(lapo[0]), 32'h0);
`endif
    check("lap_keeps_counting", 32'(dig[0]), 32'h0030);
    areset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 59) == 0) dn = ~dn;
      if ($urandom_range(0, 799) == 0) areset();
      else cyc($urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 14) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
